// File: rtl/proc_fetch.sv
// proc_fetch: instruction-fetch front end for the 9-bit proc datapath.
// Reads a synchronous-read program memory, drives Run/DIN and consumes Done.
module proc_fetch #(
  parameter int AW = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stop,
  output logic [AW-1:0] MemAddr,
  input  logic [8:0]    MemData,
  output logic [8:0]    DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_I = 3'd1;
  localparam logic [2:0] S_LATCH_I = 3'd2;
  localparam logic [2:0] S_LATCH_D = 3'd3;
  localparam logic [2:0] S_ISSUE   = 3'd4;
  localparam logic [2:0] S_EXEC    = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;

  // PC advance by one or two words, wrapping at 2^AW.
  function automatic logic [AW-1:0] pc_add(input logic [AW-1:0] pc, input logic two);
    if (two) begin
      pc_add = pc + AW'(2'b10);
    end else begin
      pc_add = pc + AW'(1'b1);
    end
  endfunction

  logic [2:0]    state_r, state_nxt_s;
  logic [AW-1:0] pc_r, pc_nxt_s;
  logic [8:0]    irbuf_r, irbuf_nxt_s;
  logic [8:0]    dbuf_r, dbuf_nxt_s;
  logic [1:0]    tmo_r, tmo_nxt_s;
  logic          halted_r, halted_nxt_s;
  logic          error_r, error_nxt_s;
  logic          run_r, run_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic [8:0]    din_r, din_nxt_s;
  logic          ismvi_s, ismvi_nxt_s;

  assign ismvi_s     = (irbuf_r[8:6] == 3'b001);
  assign ismvi_nxt_s = (irbuf_nxt_s[8:6] == 3'b001);

  // The data word of an mvi is fetched while the opcode is being latched.
  assign MemAddr = (state_r == S_LATCH_I) ? pc_add(pc_r, 1'b0) : pc_r;

  assign DIN    = din_r;
  assign Run    = run_r;
  assign PC     = pc_r;
  assign Busy   = busy_r;
  assign Halted = halted_r;
  assign Error  = error_r;

  // Sequencer next-state and buffer/flag update logic.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    irbuf_nxt_s  = irbuf_r;
    dbuf_nxt_s   = dbuf_r;
    tmo_nxt_s    = tmo_r;
    halted_nxt_s = halted_r;
    error_nxt_s  = error_r;
    case (state_r)
      S_IDLE: begin
        if (Start) begin
          state_nxt_s = S_FETCH_I;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH_I: begin
        state_nxt_s = S_LATCH_I;
      end
      S_LATCH_I: begin
        irbuf_nxt_s = MemData;
        if (MemData[8]) begin
          halted_nxt_s = 1'b1;
          state_nxt_s  = S_HALT;
        end else if (MemData[8:6] == 3'b001) begin
          state_nxt_s = S_LATCH_D;
        end else begin
          state_nxt_s = S_ISSUE;
        end
      end
      S_LATCH_D: begin
        dbuf_nxt_s  = MemData;
        state_nxt_s = S_ISSUE;
      end
      S_ISSUE: begin
        tmo_nxt_s   = 2'd0;
        state_nxt_s = S_EXEC;
      end
      S_EXEC: begin
        if (Done) begin
          pc_nxt_s = pc_add(pc_r, ismvi_s);
          if (Stop) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_FETCH_I;
          end
        end else if (tmo_r == 2'd2) begin
          // Third EXEC cycle without Done: proc is considered hung.
          error_nxt_s = 1'b1;
          state_nxt_s = S_HALT;
        end else begin
          tmo_nxt_s = tmo_r + 2'd1;
        end
      end
      S_HALT: begin
        state_nxt_s = S_HALT;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Output values for the coming state, so Run/DIN/Busy leave flops directly.
  always_comb begin
    run_nxt_s  = (state_nxt_s == S_ISSUE);
    busy_nxt_s = (state_nxt_s != S_IDLE) && (state_nxt_s != S_HALT);
    if ((state_nxt_s == S_EXEC) && ismvi_nxt_s) begin
      din_nxt_s = dbuf_nxt_s;
    end else begin
      din_nxt_s = irbuf_nxt_s;
    end
  end

  // State, buffer and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r  <= S_IDLE;
      pc_r     <= '0;
      irbuf_r  <= 9'd0;
      dbuf_r   <= 9'd0;
      tmo_r    <= 2'd0;
      halted_r <= 1'b0;
      error_r  <= 1'b0;
      run_r    <= 1'b0;
      busy_r   <= 1'b0;
      din_r    <= 9'd0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      irbuf_r  <= irbuf_nxt_s;
      dbuf_r   <= dbuf_nxt_s;
      tmo_r    <= tmo_nxt_s;
      halted_r <= halted_nxt_s;
      error_r  <= error_nxt_s;
      run_r    <= run_nxt_s;
      busy_r   <= busy_nxt_s;
      din_r    <= din_nxt_s;
    end
  end

endmodule

// File: tb/tb_proc_fetch.sv
// Bench for proc_fetch: behavioural proc/memory models, directed steps and
// random programs checked against an issue trace derived from memory contents.
module tb_proc_fetch;

  logic Clock;
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- AW=5 instance ----------------
  logic       Reset, Start, Stop, Done;
  logic [4:0] MemAddr, PC;
  logic [8:0] MemData, DIN;
  logic       Run, Busy, Halted, Error;
  logic [8:0] mem [0:31];

  proc_fetch #(.AW(5)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
    .MemAddr(MemAddr), .MemData(MemData), .DIN(DIN), .Run(Run), .Done(Done),
    .PC(PC), .Busy(Busy), .Halted(Halted), .Error(Error)
  );

  always @(posedge Clock) MemData <= mem[MemAddr];

  // Behavioural proc: mv/mvi finish in T1, add/sub in T3.
  logic       done_en;
  int         ph;
  logic [8:0] pir;
  logic [8:0] rf [0:7];
  assign Done = done_en && ((ph == 1 && pir[8:7] == 2'b00) || (ph == 3 && pir[8:7] == 2'b01));
  always @(posedge Clock) begin
    if (Reset) begin
      ph  <= 0;
      pir <= 9'd0;
    end else if (ph == 0) begin
      if (Run) begin
        ph  <= 1;
        pir <= DIN;
      end
    end else if (Done) begin
      ph <= 0;
      case (pir[8:6])
        3'b000:  rf[pir[5:3]] <= rf[pir[2:0]];
        3'b001:  rf[pir[5:3]] <= DIN;
        3'b010:  rf[pir[5:3]] <= rf[pir[5:3]] + rf[pir[2:0]];
        default: rf[pir[5:3]] <= rf[pir[5:3]] - rf[pir[2:0]];
      endcase
    end else begin
      ph <= ph + 1;
    end
  end

  // Trace monitor
  int         cyc = 0;
  logic       prev_run = 1'b0, prev_halt = 1'b0;
  logic [8:0] iss_q[$], t1_q[$];
  int         run_cyc_q[$];
  int         halt_cyc = -1;
  always @(posedge Clock) cyc <= cyc + 1;
  always @(negedge Clock) begin
    if (prev_run) t1_q.push_back(DIN);
    if (Run) begin
      iss_q.push_back(DIN);
      run_cyc_q.push_back(cyc);
    end
    if (Halted && !prev_halt) halt_cyc <= cyc;
    prev_run  <= Run;
    prev_halt <= Halted;
  end

  // ---------------- AW=2 instance ----------------
  logic       Start2, Stop2, Done2;
  logic [1:0] MemAddr2, PC2;
  logic [8:0] MemData2, DIN2;
  logic       Run2, Busy2, Halted2, Error2;
  logic [8:0] mem2 [0:3];

  proc_fetch #(.AW(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .Start(Start2), .Stop(Stop2),
    .MemAddr(MemAddr2), .MemData(MemData2), .DIN(DIN2), .Run(Run2), .Done(Done2),
    .PC(PC2), .Busy(Busy2), .Halted(Halted2), .Error(Error2)
  );

  always @(posedge Clock) MemData2 <= mem2[MemAddr2];

  int         ph2;
  logic [8:0] pir2;
  assign Done2 = (ph2 == 1 && pir2[8:7] == 2'b00) || (ph2 == 3 && pir2[8:7] == 2'b01);
  always @(posedge Clock) begin
    if (Reset) begin
      ph2  <= 0;
      pir2 <= 9'd0;
    end else if (ph2 == 0) begin
      if (Run2) begin
        ph2  <= 1;
        pir2 <= DIN2;
      end
    end else if (Done2) begin
      ph2 <= 0;
    end else begin
      ph2 <= ph2 + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; done_en = 1'b1;
    Start2 = 1'b0; Stop2 = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    iss_q.delete(); t1_q.delete(); run_cyc_q.delete();
  endtask

  // Reference trace: walk memory from address 0 using the fetch rules.
  logic [8:0] exp_ins[$], exp_t1[$];
  int         exp_run[$];
  int         exp_pc, exp_halt;

  task automatic build_expect();
    int pc, t;
    logic [8:0] w;
    exp_ins.delete(); exp_t1.delete(); exp_run.delete();
    pc = 0; t = 0; exp_pc = -1; exp_halt = -1;
    for (int k = 0; k < 40; k++) begin
      w = mem[pc];
      if (w[8]) begin
        exp_pc   = pc;
        exp_halt = t + 2;
        break;
      end
      exp_ins.push_back(w);
      if (w[8:6] == 3'b001) begin
        exp_t1.push_back(mem[(pc + 1) % 32]);
        exp_run.push_back(t + 3);
        t  += 5;
        pc = (pc + 2) % 32;
      end else begin
        exp_t1.push_back(w);
        exp_run.push_back(t + 2);
        t  += (w[7] ? 6 : 4);
        pc = (pc + 1) % 32;
      end
    end
  endtask

  task automatic run_prog(input string tag);
    int n;
    build_expect();
    do_reset();
    Start = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge Clock);
      if (Halted) break;
    end
    Start = 1'b0;
    @(negedge Clock);
    chk({tag, "_halted"}, 32'(Halted), 32'd1);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_error"}, 32'(Error), 32'd0);
    chk({tag, "_pc"}, 32'(PC), 32'(exp_pc));
    chk({tag, "_nrun"}, 32'(iss_q.size()), 32'(exp_ins.size()));
    n = (iss_q.size() < exp_ins.size()) ? iss_q.size() : exp_ins.size();
    if (t1_q.size() < n) n = t1_q.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, "_issue"}, 32'(iss_q[k]), 32'(exp_ins[k]));
      chk({tag, "_t1din"}, 32'(t1_q[k]), 32'(exp_t1[k]));
      chk({tag, "_runtime"}, 32'(run_cyc_q[k] - run_cyc_q[0]), 32'(exp_run[k] - exp_run[0]));
    end
    if (n > 0) chk({tag, "_halttime"}, 32'(halt_cyc - run_cyc_q[0]), 32'(exp_halt - exp_run[0]));
  endtask

  task automatic gen_prog();
    int a, len;
    logic [1:0] op;
    for (int i = 0; i < 32; i++) mem[i] = {1'b1, 8'($urandom)};
    len = $urandom_range(4, 24);
    a = 0;
    while (a < len) begin
      op = 2'($urandom_range(0, 3));
      mem[a] = {1'b0, op, 6'($urandom)};
      a++;
      if (op == 2'b01) begin
        mem[a] = 9'($urandom);
        a++;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int runs;
    for (int i = 0; i < 32; i++) mem[i] = 9'h100;
    mem2[0] = 9'h0AB; mem2[1] = 9'h008; mem2[2] = 9'h010; mem2[3] = 9'h040;
    Start = 1'b0; Stop = 1'b0; done_en = 1'b1; Start2 = 1'b0; Stop2 = 1'b0;

    // Reset state
    do_reset();
    chk("rst_din", 32'(DIN), 32'd0);
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_memaddr", 32'(MemAddr), 32'd0);
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_pc2", 32'(PC2), 32'd0);

    // mvi r0,5 ; add r0,r0 ; HALT
    mem[0] = 9'h040; mem[1] = 9'h005; mem[2] = 9'h080; mem[3] = 9'h100;
    run_prog("mvi_add");
    chk("mvi_add_runs", 32'(iss_q.size()), 32'd2);
    if (t1_q.size() > 0) chk("mvi_add_t1", 32'(t1_q[0]), 32'h005);
    chk("mvi_add_r0", 32'(rf[0]), 32'd10);
    chk("mvi_add_pc3", 32'(PC), 32'd3);

    // mv r1,r0 ; HALT
    for (int i = 0; i < 32; i++) mem[i] = 9'h100;
    mem[0] = 9'h008;
    run_prog("mv_halt");
    chk("mv_halt_pc1", 32'(PC), 32'd1);

    // Stop during add EXEC, then resume at address 1
    mem[0] = 9'h080; mem[1] = 9'h008; mem[2] = 9'h100;
    do_reset();
    Start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (Run) break;
    end
    chk("stop_run_seen", 32'(Run), 32'd1);
    Start = 1'b0; Stop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (!Busy) break;
    end
    chk("stop_busy", 32'(Busy), 32'd0);
    chk("stop_halted", 32'(Halted), 32'd0);
    chk("stop_pc", 32'(PC), 32'd1);
    repeat (6) @(negedge Clock);
    chk("stop_no_run", 32'(iss_q.size()), 32'd1);
    chk("stop_memaddr", 32'(MemAddr), 32'd1);
    Stop = 1'b0; Start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Halted) break;
    end
    Start = 1'b0;
    @(negedge Clock);
    chk("resume_runs", 32'(iss_q.size()), 32'd2);
    if (iss_q.size() > 1) chk("resume_instr", 32'(iss_q[1]), 32'h008);
    chk("resume_pc", 32'(PC), 32'd2);

    // Done never returns: Error on the third EXEC cycle
    mem[0] = 9'h008;
    do_reset();
    done_en = 1'b0;
    Start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (Run) break;
    end
    chk("tmo_run_seen", 32'(Run), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      chk("tmo_error_early", 32'(Error), 32'd0);
    end
    @(negedge Clock);
    chk("tmo_error", 32'(Error), 32'd1);
    chk("tmo_busy", 32'(Busy), 32'd0);
    chk("tmo_halted", 32'(Halted), 32'd0);
    runs = iss_q.size();
    repeat (10) @(negedge Clock);
    chk("tmo_start_ignored", 32'(iss_q.size()), 32'(runs));
    chk("tmo_busy_after", 32'(Busy), 32'd0);
    chk("tmo_error_sticky", 32'(Error), 32'd1);
    do_reset();
    chk("tmo_reset_clears", 32'(Error), 32'd0);

    // Reset while in LATCH_D with Start held high
    mem[0] = 9'h040; mem[1] = 9'h0AA; mem[2] = 9'h100;
    Start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (Busy && MemAddr == 5'd1) break;
    end
    chk("rstd_latch_i", 32'(MemAddr), 32'd1);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("rstd_run", 32'(Run), 32'd0);
    chk("rstd_din", 32'(DIN), 32'd0);
    chk("rstd_pc", 32'(PC), 32'd0);
    chk("rstd_busy", 32'(Busy), 32'd0);
    chk("rstd_flags", 32'({Halted, Error}), 32'd0);
    chk("rstd_memaddr", 32'(MemAddr), 32'd0);
    Reset = 1'b0; Start = 1'b0;

    // AW=2: mvi at the last address takes its data from address 0
    do_reset();
    Start2 = 1'b1;
    runs = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clock);
      if (Run2) runs++;
      if (runs == 4) break;
    end
    chk("aw2_runs", 32'(runs), 32'd4);
    chk("aw2_issue", 32'(DIN2), 32'h040);
    Start2 = 1'b0; Stop2 = 1'b1;
    @(negedge Clock);
    chk("aw2_t1din", 32'(DIN2), 32'h0AB);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (!Busy2) break;
    end
    chk("aw2_idle", 32'(Busy2), 32'd0);
    chk("aw2_pc_wrap", 32'(PC2), 32'd1);
    chk("aw2_flags", 32'({Halted2, Error2}), 32'd0);
    Stop2 = 1'b0;

    // Random programs against the reference trace
    for (int r = 0; r < 6; r++) begin
      gen_prog();
      run_prog($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
